// File: rtl/prbs_seq_pkg.sv
// Shared types and widths for the PRBS test sequencer.
package prbs_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SEED_W = 32;
    localparam int N_W    = 8;

endpackage

// File: rtl/prbs_test_sequencer_if.sv
// Link between the sequencer and the PRBS generator / pattern detector datapath.
interface prbs_test_sequencer_if;
    import prbs_seq_pkg::*;

    logic              prbs_rstn;
    logic [SEED_W-1:0] prbs_seed;
    logic [N_W-1:0]    prbs_n;
    logic              pattern_detected;

    modport master (
        output prbs_rstn,
        output prbs_seed,
        output prbs_n,
        input  pattern_detected
    );

    modport slave (
        input  prbs_rstn,
        input  prbs_seed,
        input  prbs_n,
        output pattern_detected
    );

endinterface

// File: rtl/prbs_seq_timer.sv
// Up-counter with clear/enable and a terminal flag raised when cnt == limit-1.
module prbs_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/prbs_test_sequencer.sv
// Run controller for the PRBS generator + pattern detector pair.
// Define PRBS_SEQ_HITCNT_EN to add the saturating hit_count output.
//
//   state | meaning
//   IDLE  | PRBS path held in reset, waiting for start
//   LOAD  | PRBS path held in reset RST_CYCLES cycles to reload the seed
//   RUN   | PRBS released, watching pattern_detected against the budget
//   DONE  | PRBS keeps running, run status held until next start/abort
module prbs_test_sequencer
    import prbs_seq_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [SEED_W-1:0] cfg_seed,
    input  logic [N_W-1:0]    cfg_n,
    input  logic [CNT_W-1:0]  cfg_limit,
    prbs_test_sequencer_if.master dp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              err,
    output logic [CNT_W-1:0]  hit_cycle
`ifdef PRBS_SEQ_HITCNT_EN
    ,
    output logic [15:0]       hit_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_LOAD = 2'(LOAD);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    localparam logic [CNT_W-1:0] LOAD_LIMIT = CNT_W'(RST_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  hit_cycle_q, hit_cycle_d;
    logic              prbs_rstn_q, prbs_rstn_d;
`ifdef PRBS_SEQ_HITCNT_EN
    logic [15:0]       hit_count_q, hit_count_d;
`endif

    logic             load_tc, run_tc;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] load_cnt_unused;
    logic             cfg_ok;

    assign cfg_ok = (cfg_n != '0) && (cfg_limit != '0);

    // Timers free-run only in their own state; abort clears them with the FSM.
    prbs_seq_timer #(.CNT_W(CNT_W)) u_load_timer (
        .clk   (CLK),
        .rst   (RST),
        .clr   (abort || (state_q != ST_LOAD)),
        .en    (state_q == ST_LOAD),
        .limit (LOAD_LIMIT),
        .cnt   (load_cnt_unused),
        .tc    (load_tc)
    );

    prbs_seq_timer #(.CNT_W(CNT_W)) u_run_timer (
        .clk   (CLK),
        .rst   (RST),
        .clr   (abort || (state_q != ST_RUN)),
        .en    (state_q == ST_RUN),
        .limit (limit_q),
        .cnt   (run_cnt),
        .tc    (run_tc)
    );

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        n_d         = n_q;
        limit_d     = limit_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        hit_cycle_d = hit_cycle_q;

        if (abort) begin
            state_d     = ST_IDLE;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
            err_d       = 1'b0;
            hit_cycle_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pass_d      = 1'b0;
                        timeout_d   = 1'b0;
                        hit_cycle_d = '0;
                        if (cfg_ok) begin
                            state_d = ST_LOAD;
                            seed_d  = cfg_seed;
                            n_d     = cfg_n;
                            limit_d = cfg_limit;
                            err_d   = 1'b0;
                        end else begin
                            state_d = ST_DONE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_tc) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Detection is checked first so a hit on the last budget cycle passes.
                    if (dp.pattern_detected) begin
                        state_d     = ST_DONE;
                        pass_d      = 1'b1;
                        hit_cycle_d = run_cnt;
                    end else if (run_tc) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        prbs_rstn_d = (state_d == ST_RUN) || (state_d == ST_DONE);

`ifdef PRBS_SEQ_HITCNT_EN
        hit_count_d = hit_count_q;
        if ((state_q == ST_RUN) && (state_d == ST_DONE) && pass_d &&
            (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            n_q         <= '0;
            limit_q     <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
            hit_cycle_q <= '0;
            prbs_rstn_q <= 1'b0;
`ifdef PRBS_SEQ_HITCNT_EN
            hit_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            n_q         <= n_d;
            limit_q     <= limit_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            hit_cycle_q <= hit_cycle_d;
            prbs_rstn_q <= prbs_rstn_d;
`ifdef PRBS_SEQ_HITCNT_EN
            hit_count_q <= hit_count_d;
`endif
        end
    end

    assign dp.prbs_rstn = prbs_rstn_q;
    assign dp.prbs_seed = seed_q;
    assign dp.prbs_n    = n_q;

    assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err       = err_q;
    assign hit_cycle = hit_cycle_q;
`ifdef PRBS_SEQ_HITCNT_EN
    assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// Directed self-checking bench for prbs_test_sequencer (RST_CYCLES=2, CNT_W=16).
module tb_prbs_test_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        abort;
    logic [31:0] cfg_seed;
    logic [7:0]  cfg_n;
    logic [15:0] cfg_limit;
    logic        busy, done, pass, timeout, err;
    logic [15:0] hit_cycle;
`ifdef PRBS_SEQ_HITCNT_EN
    logic [15:0] hit_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int low_cyc, run_cyc;

    prbs_test_sequencer_if dp ();

    prbs_test_sequencer #(.RST_CYCLES(2), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .cfg_seed  (cfg_seed),
        .cfg_n     (cfg_n),
        .cfg_limit (cfg_limit),
        .dp        (dp.master),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err       (err),
        .hit_cycle (hit_cycle)
`ifdef PRBS_SEQ_HITCNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Start a run, optionally hold pattern_detected high through LOAD, then
    // pulse it on RUN cycle detect_at (-1 = never). Returns LOAD and RUN lengths.
    task automatic do_run(input logic [31:0] seed, input logic [7:0] n, input logic [15:0] limit,
                          input int detect_at, input bit pd_load,
                          output int low_c, output int run_c);
        int guard;
        cfg_seed = seed;
        cfg_n    = n;
        cfg_limit = limit;
        start = 1'b1;
        tick();
        start = 1'b0;
        low_c = 0;
        guard = 0;
        while (busy && !dp.prbs_rstn && guard < 40) begin
            dp.pattern_detected = pd_load;
            low_c++;
            guard++;
            tick();
        end
        dp.pattern_detected = 1'b0;
        run_c = 0;
        while (busy && run_c < int'(limit) + 5) begin
            dp.pattern_detected = (run_c == detect_at);
            run_c++;
            tick();
        end
        dp.pattern_detected = 1'b0;
        check("run_ends_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_seed = '0;
        cfg_n = '0;
        cfg_limit = '0;
        dp.pattern_detected = 1'b0;
        tick();
        tick();
        RST = 1'b0;

        check("rst_prbs_rstn", {31'd0, dp.prbs_rstn}, 32'd0);
        check("rst_seed", dp.prbs_seed, 32'd0);
        check("rst_n", {24'd0, dp.prbs_n}, 32'd0);
        check("rst_flags", {27'd0, busy, done, pass, timeout, err}, 32'd0);
        check("rst_hit_cycle", {16'd0, hit_cycle}, 32'd0);

        // 1: normal hit on RUN cycle 37
        do_run(32'hAABBCCDD, 8'd8, 16'd100, 37, 1'b0, low_cyc, run_cyc);
        check("t1_low_cycles", low_cyc, 32'd2);
        check("t1_run_cycles", run_cyc, 32'd38);
        check("t1_pass_timeout", {30'd0, pass, timeout}, 32'b10);
        check("t1_hit_cycle", {16'd0, hit_cycle}, 32'd37);
        check("t1_seed", dp.prbs_seed, 32'hAABBCCDD);
        check("t1_n", {24'd0, dp.prbs_n}, 32'd8);
        check("t1_rstn_done", {30'd0, dp.prbs_rstn, busy}, 32'b10);
        tick();
        check("t1_done_level", {31'd0, done}, 32'd1);

        // 2: timeout with no detect
        do_run(32'h12345678, 8'd7, 16'd10, -1, 1'b0, low_cyc, run_cyc);
        check("t2_low_cycles", low_cyc, 32'd2);
        check("t2_run_cycles", run_cyc, 32'd10);
        check("t2_pass_timeout", {30'd0, pass, timeout}, 32'b01);
        check("t2_hit_cycle", {16'd0, hit_cycle}, 32'd0);

        // 3: detect on the last budget cycle, then detect only during LOAD
        do_run(32'h0000BEEF, 8'd9, 16'd10, 9, 1'b0, low_cyc, run_cyc);
        check("t3_run_cycles", run_cyc, 32'd10);
        check("t3_pass_timeout", {30'd0, pass, timeout}, 32'b10);
        check("t3_hit_cycle", {16'd0, hit_cycle}, 32'd9);
        do_run(32'h0000BEEF, 8'd9, 16'd10, -1, 1'b1, low_cyc, run_cyc);
        check("t3_load_pd_timeout", {30'd0, pass, timeout}, 32'b01);
        check("t3_load_pd_hit", {16'd0, hit_cycle}, 32'd0);

        // 4: rejected starts
        cfg_seed = 32'h55555555;
        cfg_n = 8'd0;
        cfg_limit = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_n0_flags", {27'd0, busy, done, pass, timeout, err}, 32'b01001);
        check("t4_n0_prbs_n", {24'd0, dp.prbs_n}, 32'd9);
        check("t4_n0_seed", dp.prbs_seed, 32'h0000BEEF);
        cfg_n = 8'd5;
        cfg_limit = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_lim0_err", {30'd0, done, err}, 32'b11);
        check("t4_lim0_prbs_n", {24'd0, dp.prbs_n}, 32'd9);

        // 5a: abort on RUN cycle 5
        cfg_seed = 32'hCAFEF00D;
        cfg_n = 8'd6;
        cfg_limit = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 + 5; i++) tick();
        check("t5_in_run", {30'd0, busy, dp.prbs_rstn}, 32'b11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_flags", {27'd0, busy, done, pass, timeout, err}, 32'd0);
        check("t5_abort_rstn", {31'd0, dp.prbs_rstn}, 32'd0);
        check("t5_abort_hit", {16'd0, hit_cycle}, 32'd0);

        // 5b: RST during LOAD
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_rst_in_load", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_rst_seed", dp.prbs_seed, 32'd0);
        check("t5_rst_n", {24'd0, dp.prbs_n}, 32'd0);
        check("t5_rst_flags", {26'd0, dp.prbs_rstn, busy, done, pass, timeout, err}, 32'd0);

        // 5c: start while busy is ignored; original budget of 20 still applies
        cfg_seed = 32'h11112222;
        cfg_n = 8'd7;
        cfg_limit = 16'd20;
        start = 1'b1;
        tick();
        cfg_seed = 32'h99999999;
        cfg_n = 8'd3;
        cfg_limit = 16'd2;
        tick();
        start = 1'b0;
        check("t5_busy_seed", dp.prbs_seed, 32'h11112222);
        check("t5_busy_n", {24'd0, dp.prbs_n}, 32'd7);
        run_cyc = 0;
        while (busy && run_cyc < 60) begin
            run_cyc++;
            tick();
        end
        check("t5_busy_timeout", {29'd0, done, pass, timeout}, 32'b101);
        // one LOAD cycle remains after the ignored start, then 20 RUN cycles
        check("t5_busy_cycles", run_cyc, 32'd21);

        // 5d: start and abort together from DONE
        cfg_n = 8'd4;
        cfg_limit = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort", {28'd0, busy, done, timeout, dp.prbs_rstn}, 32'd0);

`ifdef PRBS_SEQ_HITCNT_EN
        RST = 1'b1;
        tick();
        RST = 1'b0;
        do_run(32'h1, 8'd8, 16'd20, 3, 1'b0, low_cyc, run_cyc);
        do_run(32'h2, 8'd8, 16'd20, -1, 1'b0, low_cyc, run_cyc);
        do_run(32'h3, 8'd8, 16'd20, 0, 1'b0, low_cyc, run_cyc);
        do_run(32'h4, 8'd8, 16'd20, 19, 1'b0, low_cyc, run_cyc);
        check("t6_hit_count", {16'd0, hit_count}, 32'd3);
        force dut.hit_count_q = 16'hFFFF;
        tick();
        release dut.hit_count_q;
        do_run(32'h5, 8'd8, 16'd20, 2, 1'b0, low_cyc, run_cyc);
        check("t6_hit_count_sat", {16'd0, hit_count}, 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
